// File: rtl/mips_reg_file_if.sv
// mips_reg_file_if: operand-read and writeback-write bus of the MIPS register file.
//   RegA1/RegB1/RegC1   read indices (rs, rt, destination/store-data)
//   DataA1/DataB1/DataC1 combinational read data
//   WriteReg1/WriteData1/Write1 writeback port
// master = decode/writeback side, slave = register file.
interface mips_reg_file_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] RegA1;
  logic [ADDR_WIDTH-1:0] RegB1;
  logic [ADDR_WIDTH-1:0] RegC1;
  logic [DATA_WIDTH-1:0] DataA1;
  logic [DATA_WIDTH-1:0] DataB1;
  logic [DATA_WIDTH-1:0] DataC1;
  logic [ADDR_WIDTH-1:0] WriteReg1;
  logic [DATA_WIDTH-1:0] WriteData1;
  logic                  Write1;

  modport master (
    output RegA1, RegB1, RegC1, WriteReg1, WriteData1, Write1,
    input  DataA1, DataB1, DataC1
  );

  modport slave (
    input  RegA1, RegB1, RegC1, WriteReg1, WriteData1, Write1,
    output DataA1, DataB1, DataC1
  );
endinterface

// File: rtl/mips_reg_file.sv
// mips_reg_file: 2**ADDR_WIDTH x DATA_WIDTH flop-based register file with three
// combinational read ports and one synchronous write port. Register 0 reads zero.
//   CLK    clock, writes on rising edge
//   RESET  asynchronous active-low reset, clears every register
//   rf     mips_reg_file_if.slave (read indices/data, writeback port)
// Optional build macro REGFILE_BYPASS_EN: a same-cycle write to a register being
// read is forwarded to that read port (write-first behaviour).
module mips_reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic            CLK,
  input  logic            RESET,
  mips_reg_file_if.slave  rf
);

  localparam int unsigned NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam int unsigned NUM_PORTS = 3;

  logic [DATA_WIDTH-1:0] regs    [NUM_REGS];
  logic [ADDR_WIDTH-1:0] rd_idx  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rd_data [NUM_PORTS];
  logic                  wr_en;

  // Writes to r0 are dropped so the zero register never holds data.
  assign wr_en = rf.Write1 && (rf.WriteReg1 != '0);

  // Storage array; reset clears every entry.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rf.WriteReg1] <= rf.WriteData1;
    end
  end

  assign rd_idx[0] = rf.RegA1;
  assign rd_idx[1] = rf.RegB1;
  assign rd_idx[2] = rf.RegC1;

  // Read ports; outputs are forced to zero while reset is held so the
  // bypass path cannot leak writeback data during reset.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rd_data[p] = '0;
      if (RESET && (rd_idx[p] != '0)) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (rf.WriteReg1 == rd_idx[p])) begin
          rd_data[p] = rf.WriteData1;
        end else begin
          rd_data[p] = regs[rd_idx[p]];
        end
`else
        rd_data[p] = regs[rd_idx[p]];
`endif
      end
    end
  end

  assign rf.DataA1 = rd_data[0];
  assign rf.DataB1 = rd_data[1];
  assign rf.DataC1 = rd_data[2];

endmodule

// File: tb/tb_mips_reg_file.sv
// tb_mips_reg_file: randomized + directed scoreboard bench for mips_reg_file.
// Stimulus computes expected read data from an array model and queues it; a
// monitor on the falling edge pops and compares against the DUT outputs.
module tb_mips_reg_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;

  typedef struct {
    string          name;
    int             port;
    logic [AW-1:0]  idx;
    logic [DW-1:0]  exp;
  } sb_entry_t;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  always #5 CLK = ~CLK;

  mips_reg_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mips_reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .rf    (bus)
  );

  logic [DW-1:0] mdl [NR];
  sb_entry_t     sb  [$];
  int            total = 0;
  int            bad   = 0;

  // Architectural read: zero in reset, zero for r0, optional same-cycle forward.
  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] idx);
    if (!RESET) return '0;
    if (idx == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.Write1 && bus.WriteReg1 == idx) return bus.WriteData1;
`endif
    return mdl[idx];
  endfunction

  // Monitor: compare every queued expectation at the falling edge.
  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      sb_entry_t     e;
      logic [DW-1:0] act;
      e = sb.pop_front();
      case (e.port)
        0:       act = bus.DataA1;
        1:       act = bus.DataB1;
        default: act = bus.DataC1;
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s port%0d r%0d: got 0x%08h expected 0x%08h",
                 e.name, e.port, e.idx, act, e.exp);
      end
    end
  end

  task automatic push(input string name, input int port, input logic [AW-1:0] idx);
    sb_entry_t e;
    e.name = name;
    e.port = port;
    e.idx  = idx;
    e.exp  = model_read(idx);
    sb.push_back(e);
  endtask

  // One cycle: drive, queue expectations, let monitor check, then clock the model.
  task automatic step(input string name, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                      input logic [AW-1:0] rb, input logic [AW-1:0] rc);
    bus.Write1     = we;
    bus.WriteReg1  = wa;
    bus.WriteData1 = wd;
    bus.RegA1      = ra;
    bus.RegB1      = rb;
    bus.RegC1      = rc;
    #1;
    push(name, 0, ra);
    push(name, 1, rb);
    push(name, 2, rc);
    @(negedge CLK);
    @(posedge CLK);
    if (RESET && we && wa != 0) mdl[wa] = wd;
    #1;
  endtask

  task automatic enter_reset();
    RESET = 1'b0;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    bus.Write1 = 1'b0; bus.WriteReg1 = '0; bus.WriteData1 = '0;
    bus.RegA1 = '0; bus.RegB1 = '0; bus.RegC1 = '0;
    repeat (2) @(posedge CLK);
    #1;
    step("reset_state", 1'b0, 5'd0, 32'h0, 5'd1, 5'd17, 5'd31);
    RESET = 1'b1;

    step("basic_wr", 1'b1, 5'd8, 32'h12345678, 5'd8, 5'd8, 5'd8);
    step("basic_rd", 1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 5'd8);

    step("zero_wr", 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    step("zero_rd", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

    step("we_gate_wr", 1'b0, 5'd3, 32'hAAAA5555, 5'd3, 5'd3, 5'd3);
    step("we_gate_rd", 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);

    step("bypass_init", 1'b1, 5'd9, 32'h1, 5'd0, 5'd0, 5'd0);
    step("bypass_same", 1'b1, 5'd9, 32'h2, 5'd0, 5'd9, 5'd0);
    step("bypass_after", 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);

    step("indep_w1", 1'b1, 5'd1, 32'h11, 5'd1, 5'd2, 5'd31);
    step("indep_w2", 1'b1, 5'd2, 32'h22, 5'd1, 5'd2, 5'd31);
    step("indep_w31", 1'b1, 5'd31, 32'h3131, 5'd1, 5'd2, 5'd31);
    step("indep_rd", 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd31);
    step("indep_rw1", 1'b1, 5'd1, 32'h99, 5'd1, 5'd2, 5'd31);
    step("indep_rd2", 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd31);

    step("b2b_w0", 1'b1, 5'd7, 32'hA0A0A0A0, 5'd7, 5'd6, 5'd7);
    step("b2b_w1", 1'b1, 5'd7, 32'h0B0B0B0B, 5'd7, 5'd6, 5'd7);
    step("b2b_rd", 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);

    // Asynchronous reset mid-cycle, then writes attempted while held.
    step("pre_rst_wr", 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
    step("pre_rst_rd", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
    enter_reset();
    step("rst_async", 1'b1, 5'd5, 32'h777, 5'd5, 5'd5, 5'd5);
    for (int i = 0; i < NR; i++) begin
      step("rst_scan", 1'b1, AW'(i), $urandom, AW'(i), AW'(i + 1), AW'(i + 2));
    end
    RESET = 1'b1;
    step("rst_rel_wr", 1'b1, 5'd4, 32'hCAFE, 5'd5, 5'd4, 5'd8);
    step("rst_rel_rd", 1'b0, 5'd0, 32'h0, 5'd4, 5'd5, 5'd8);

    // Randomized traffic; reads are biased toward the write index.
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] wa, ra, rb, rc;
      logic          we;
      wa = AW'($urandom);
      we = ($urandom_range(0, 3) != 0);
      ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
      rc = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom);
      step("random", we, wa, $urandom, ra, rb, rc);
    end

    @(negedge CLK);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_reg_file.md
Name: mips_reg_file

Overview:
- General-purpose register file for the MIPS instruction-decode stage.
- Provides 3 asynchronous read ports (rs, rt, destination register) and 1 synchronous write port.
- The write port is driven by writeback; the read ports feed operand selection and store-data in decode.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of every data port.
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH registers.

Ports:
- CLK  input  1  clock; all writes occur on its rising edge.
- RESET  input  1  asynchronous, active-low reset; clears every register.
- RegA1  input  ADDR_WIDTH  read port A index (rs).
- RegB1  input  ADDR_WIDTH  read port B index (rt).
- RegC1  input  ADDR_WIDTH  read port C index (destination register, used for store data).
- DataA1  output  DATA_WIDTH  contents of register RegA1.
- DataB1  output  DATA_WIDTH  contents of register RegB1.
- DataC1  output  DATA_WIDTH  contents of register RegC1.
- WriteReg1  input  ADDR_WIDTH  write index from writeback.
- WriteData1  input  DATA_WIDTH  write data from writeback.
- Write1  input  1  write enable.

Behaviour:
- Storage: 2**ADDR_WIDTH x DATA_WIDTH array of flops (no RAM macro), so reset can clear every entry.
- Reset:
  - RESET low asynchronously clears all registers to 0, independent of CLK.
  - While RESET is low, writes are ignored and all read outputs return 0.
  - Release takes effect at the next rising CLK edge; the first write can land on that edge.
- Write:
  - On posedge CLK with RESET high and Write1=1, reg[WriteReg1] <= WriteData1.
  - Writes to index 0 are discarded.
  - Write1=0 leaves the array unchanged.
- Read:
  - Purely combinational, zero latency.
  - DataX1 = reg[RegX1] for each port X in {A,B,C}.
  - Index 0 always reads 0, regardless of prior write attempts.
  - Ports are independent: any combination of equal or distinct indices is legal, and equal indices return identical data.
- Read-during-write on the same cycle with matching index: result depends on REGFILE_BYPASS_EN (see below).
- Back-to-back writes to the same index on consecutive edges: the last write wins. There is no other hazard logic inside the block.
- Out-of-range indices cannot occur (full ADDR_WIDTH decode).
- No X propagation: all outputs are defined at all times after reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-before-read bypass):
  - When Write1=1, WriteReg1!=0 and WriteReg1==RegX1, DataX1 returns WriteData1 combinationally in the same cycle, for each port X independently.
  - This gives the write-first-half/read-second-half semantics, so the decode stage does not need a forwarding path from writeback.
- Not defined:
  - DataX1 returns the stored array value; the newly written data is visible only after the rising edge.
  - The decode stage must then stall or forward one extra cycle.

Test Plan:
- Reset: drive RESET low mid-simulation after writing 0xDEADBEEF to r5 -> DataA1 with RegA1=5 reads 0 immediately (asynchronous), and all 32 registers read 0.
- Basic write/read: Write1=1, WriteReg1=8, WriteData1=0x12345678, one edge; then RegA1=8, RegB1=8, RegC1=8 -> all three ports read 0x12345678.
- Zero register: Write1=1, WriteReg1=0, WriteData1=0xFFFFFFFF, one edge -> DataA1 with RegA1=0 reads 0.
- Write-enable gating: Write1=0, WriteReg1=3, WriteData1=0xAAAA5555, one edge -> r3 still reads its previous value 0.
- Bypass: r9=0x1, then same cycle Write1=1, WriteReg1=9, WriteData1=0x2, RegB1=9 before the edge:
  - With REGFILE_BYPASS_EN: DataB1=0x2.
  - Without it: DataB1=0x1.
  - After the edge, both builds read 0x2.
- Independent ports: write r1=0x11, r2=0x22, r31=0x3131 on consecutive edges; RegA1=1, RegB1=2, RegC1=31 -> 0x11, 0x22, 0x3131 simultaneously; rewrite r1=0x99 on the next edge -> DataA1=0x99, other ports unchanged.
